// File: rtl/load_store_writeback.sv
// load_store_writeback: execute-stage back end. ALU-class results are written
// back one cycle after START. Loads and stores run a request/grant/response
// exchange with data memory, with byte-lane masking and sign/zero extension.
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, a load that has
// been granted but sees no MEM_RVALID within TIMEOUT_CYCLES WAIT_R cycles is
// aborted with ERR.
//
// Memory handshake: MEM_REQ is the valid and MEM_GNT is the ready. The request
// fields (MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA) stay stable while MEM_REQ=1. The
// request transfers on the first rising edge with MEM_REQ && MEM_GNT, and
// MEM_REQ drops in the next cycle. For loads, exactly one MEM_RVALID beat is
// then accepted, and only while the FSM is in WAIT_R.
module load_store_writeback #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        START,
   input  logic [6:0]  OPCODE,
   input  logic [2:0]  FUNCT3,
   input  logic [4:0]  RD,
   input  logic [31:0] ALU_RESULT,
   input  logic [31:0] RS2_DATA,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic [3:0]  MEM_BE,
   input  logic        MEM_GNT,
   input  logic        MEM_RVALID,
   input  logic [31:0] MEM_RDATA,
   output logic        WB_EN,
   output logic [4:0]  WB_RD,
   output logic [31:0] WB_DATA,
   output logic        DONE,
   output logic        ERR,
   output logic        BUSY,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALU_WB = 3'd1,
      S_REQ    = 3'd2,
      S_WAIT_R = 3'd3,
      S_LD_WB  = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t      state;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;
   logic [1:0]  lane_q;

   logic        is_alu, is_load, is_store;
   logic        f3_ok, aligned, ls_ok;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;
`endif

   // Pick the lane out of a read word and extend it according to funct3.
   function automatic logic [31:0] extract(input logic [2:0] f3,
                                           input logic [1:0] lane,
                                           input logic [31:0] w);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = w >> {lane, 3'b000};
      b  = sh[7:0];
      h  = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b100:  extract = {24'b0, b};
         3'b101:  extract = {16'b0, h};
         default: extract = w;
      endcase
   endfunction

   // Decode the op presented with START: its class, legality, lane mask and store data.
   always_comb begin
      is_alu   = (OPCODE == 7'b0010011) || (OPCODE == 7'b0110011) ||
                 (OPCODE == 7'b0110111) || (OPCODE == 7'b0010111);
      is_load  = (OPCODE == 7'b0000011);
      is_store = (OPCODE == 7'b0100011);
      f3_ok    = is_load ? (FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                         : (FUNCT3 inside {3'b000, 3'b001, 3'b010});
      aligned  = 1'b1;
      if (FUNCT3[1:0] == 2'b01) aligned = ~ALU_RESULT[0];
      if (FUNCT3[1:0] == 2'b10) aligned = (ALU_RESULT[1:0] == 2'b00);
      ls_ok    = f3_ok && aligned;
      case (FUNCT3[1:0])
         2'b00: begin
            be_in    = 4'b0001 << ALU_RESULT[1:0];
            wdata_in = {4{RS2_DATA[7:0]}};
         end
         2'b01: begin
            be_in    = 4'b0011 << ALU_RESULT[1:0];
            wdata_in = {2{RS2_DATA[15:0]}};
         end
         default: begin
            be_in    = 4'b1111;
            wdata_in = RS2_DATA;
         end
      endcase
   end

   // Control FSM. All outputs are registered, and WB_EN/DONE/ERR are single-cycle pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         MEM_REQ   <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         MEM_BE    <= '0;
         WB_EN     <= 1'b0;
         WB_RD     <= '0;
         WB_DATA   <= '0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         f3_q      <= '0;
         rd_q      <= '0;
         lane_q    <= '0;
`ifdef LSU_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         WB_EN <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START && (is_alu || is_load || is_store)) begin
                  f3_q   <= FUNCT3;
                  rd_q   <= RD;
                  lane_q <= ALU_RESULT[1:0];
                  if (is_alu) begin
                     state   <= S_ALU_WB;
                     WB_EN   <= (RD != 5'd0);
                     WB_RD   <= RD;
                     WB_DATA <= ALU_RESULT;
                     DONE    <= 1'b1;
                  end else if (!ls_ok) begin
                     state <= S_FIN;
                     ERR   <= 1'b1;
                     DONE  <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     MEM_REQ   <= 1'b1;
                     MEM_WE    <= is_store;
                     MEM_ADDR  <= {ALU_RESULT[31:2], 2'b00};
                     MEM_BE    <= be_in;
                     MEM_WDATA <= wdata_in;
                  end
               end
            end
            S_REQ: begin
               if (MEM_GNT) begin
                  MEM_REQ <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                  to_cnt  <= '0;
`endif
                  if (MEM_WE) begin
                     state <= S_FIN;
                     DONE  <= 1'b1;
                  end else begin
                     state <= S_WAIT_R;
                  end
               end
            end
            S_WAIT_R: begin
               if (MEM_RVALID) begin
                  state   <= S_LD_WB;
                  WB_EN   <= (rd_q != 5'd0);
                  WB_RD   <= rd_q;
                  WB_DATA <= extract(f3_q, lane_q, MEM_RDATA);
                  DONE    <= 1'b1;
               end
`ifdef LSU_TIMEOUT_EN
               else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  state <= S_FIN;
                  ERR   <= 1'b1;
                  DONE  <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_ALU_WB, S_LD_WB, S_FIN: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign BUSY      = (state != S_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_load_store_writeback.sv
// tb_load_store_writeback: self-checking bench for load_store_writeback.
// The bench plays the role of the memory. Expected results come from a
// size/offset arithmetic model of the load/store rules.
module tb_load_store_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        START = 1'b0;
  logic [6:0]  OPCODE = '0;
  logic [2:0]  FUNCT3 = '0;
  logic [4:0]  RD = '0;
  logic [31:0] ALU_RESULT = '0;
  logic [31:0] RS2_DATA = '0;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic        MEM_GNT = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;
  logic        WB_EN;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic        DONE, ERR, BUSY;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  load_store_writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .START(START), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
    .RD(RD), .ALU_RESULT(ALU_RESULT), .RS2_DATA(RS2_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_BE(MEM_BE), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .DONE(DONE), .ERR(ERR),
    .BUSY(BUSY), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lane);
    int m;
    m = ((1 << size_of(f3)) - 1) << lane;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (size_of(f3) == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (size_of(f3) == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
    logic [63:0] v;
    int n;
    n = size_of(f3);
    if (n == 4) return w;
    v = ({32'b0, w} >> (8 * lane)) % (64'd1 << (8 * n));
    if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic bit model_legal(input bit is_load, input logic [2:0] f3,
                                     input logic [31:0] addr);
    if (is_load && (f3 == 3 || f3 == 6 || f3 == 7)) return 0;
    if (!is_load && f3 >= 3) return 0;
    return (addr % size_of(f3)) == 0;
  endfunction

  // driver tasks (each does its own checks)
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, WB_EN, WB_RD, WB_DATA, DONE, ERR, BUSY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b be=%h wb=%b done=%b err=%b busy=%b expected all 0",
               MEM_REQ, MEM_BE, WB_EN, DONE, ERR, BUSY);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic run_alu(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] res);
    OPCODE = op; FUNCT3 = 3'($urandom); RD = rd; ALU_RESULT = res; RS2_DATA = $urandom; START = 1'b1;
    tick();
    START = 1'b0; ALU_RESULT = $urandom; RD = 5'($urandom);
    checks++;
    if ({WB_EN, DONE, ERR, MEM_REQ, BUSY} !== {rd != 5'd0, 1'b1, 1'b0, 1'b0, 1'b1} ||
        (rd != 5'd0 && {WB_RD, WB_DATA} !== {rd, res})) begin
      errors++;
      $display("FAIL alu_wb got en=%b rd=%0d data=%h done=%b expected en=%b rd=%0d data=%h done=1",
               WB_EN, WB_RD, WB_DATA, DONE, rd != 5'd0, rd, res);
    end
    tick();
    checks++;
    if ({BUSY, WB_EN, DONE} !== 3'b000) begin
      errors++;
      $display("FAIL alu_idle got busy=%b en=%b done=%b expected 000", BUSY, WB_EN, DONE);
    end
  endtask

  task automatic test_alu();
    logic [6:0] ops[4] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111};
    run_alu(7'b0010011, 5'd5, 32'h0000_002A);
    run_alu(7'b0010011, 5'd0, 32'h0000_002A);
    for (int i = 0; i < 8; i++)
      run_alu(ops[$urandom_range(0, 3)], 5'($urandom), $urandom);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input bit rv_with_gnt);
    logic [31:0] exp;
    bit early;
    exp_q.push_back(model_load(f3, addr[1:0], rdata));
    OPCODE = OP_LOAD; FUNCT3 = f3; RD = rd; ALU_RESULT = addr; RS2_DATA = $urandom; START = 1'b1;
    tick();
    START = 1'b0; OPCODE = 7'($urandom); FUNCT3 = 3'($urandom); ALU_RESULT = $urandom; RD = 5'($urandom);
    for (int i = 0; i <= gnt_dly; i++) begin
      checks++;
      if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, BUSY} !==
          {1'b1, 1'b0, addr & ~32'h3, model_be(f3, addr[1:0]), 1'b1}) begin
        errors++;
        $display("FAIL load_req got req=%b we=%b addr=%h be=%b expected req=1 we=0 addr=%h be=%b",
                 MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, addr & ~32'h3, model_be(f3, addr[1:0]));
      end
      MEM_GNT = (i == gnt_dly);
      if (i == gnt_dly && rv_with_gnt) begin
        MEM_RVALID = 1'b1; MEM_RDATA = ~rdata;
      end
      tick();
      MEM_RVALID = 1'b0;
    end
    MEM_GNT = 1'b0;
    early = 0;
    for (int i = 0; i < rv_dly; i++) begin
      if (MEM_REQ || DONE || WB_EN || !BUSY) early = 1;
      tick();
    end
    checks++;
    if (early || MEM_REQ || DONE || WB_EN || !BUSY) begin
      errors++;
      $display("FAIL load_wait got req=%b done=%b en=%b busy=%b early=%b expected waiting",
               MEM_REQ, DONE, WB_EN, BUSY, early);
    end
    MEM_RVALID = 1'b1; MEM_RDATA = rdata;
    tick();
    MEM_RVALID = 1'b0; MEM_RDATA = $urandom;
    exp = exp_q.pop_front();
    checks++;
    if ({WB_EN, DONE, ERR} !== {rd != 5'd0, 1'b1, 1'b0} ||
        (rd != 5'd0 && {WB_RD, WB_DATA} !== {rd, exp})) begin
      errors++;
      $display("FAIL load_wb f3=%0d addr=%h got en=%b rd=%0d data=%h done=%b expected en=%b rd=%0d data=%h",
               f3, addr, WB_EN, WB_RD, WB_DATA, DONE, rd != 5'd0, rd, exp);
    end
    tick();
    checks++;
    if ({BUSY, WB_EN, DONE} !== 3'b000) begin
      errors++;
      $display("FAIL load_idle got busy=%b en=%b done=%b expected 000", BUSY, WB_EN, DONE);
    end
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d,
                           input int gnt_dly, input bit poke);
    OPCODE = OP_STORE; FUNCT3 = f3; RD = 5'($urandom); ALU_RESULT = addr; RS2_DATA = d; START = 1'b1;
    tick();
    START = 1'b0; OPCODE = 7'($urandom); ALU_RESULT = $urandom; RS2_DATA = $urandom;
    for (int i = 0; i <= gnt_dly; i++) begin
      checks++;
      if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA, WB_EN, DONE} !==
          {1'b1, 1'b1, addr & ~32'h3, model_be(f3, addr[1:0]), model_wdata(f3, d), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL store_req got req=%b we=%b addr=%h be=%b wdata=%h expected req=1 we=1 addr=%h be=%b wdata=%h",
                 MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA, addr & ~32'h3,
                 model_be(f3, addr[1:0]), model_wdata(f3, d));
      end
      if (poke && i == 0) begin
        START = 1'b1; OPCODE = 7'b0010011; RD = 5'd7; ALU_RESULT = 32'h1234_5678;
      end
      MEM_GNT = (i == gnt_dly);
      tick();
      START = 1'b0;
    end
    MEM_GNT = 1'b0;
    checks++;
    if ({DONE, ERR, WB_EN, MEM_REQ} !== 4'b1000) begin
      errors++;
      $display("FAIL store_done got done=%b err=%b en=%b req=%b expected 1000", DONE, ERR, WB_EN, MEM_REQ);
    end
    tick();
    checks++;
    if ({BUSY, WB_EN, DONE} !== 3'b000) begin
      errors++;
      $display("FAIL store_idle got busy=%b en=%b done=%b expected 000", BUSY, WB_EN, DONE);
    end
  endtask

  task automatic run_err(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
    OPCODE = op; FUNCT3 = f3; RD = 5'($urandom_range(1, 31)); ALU_RESULT = addr; RS2_DATA = $urandom;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if ({ERR, DONE, MEM_REQ, WB_EN, BUSY} !== 5'b11001) begin
      errors++;
      $display("FAIL err_pulse f3=%0d addr=%h got err=%b done=%b req=%b en=%b busy=%b expected 11001",
               f3, addr, ERR, DONE, MEM_REQ, WB_EN, BUSY);
    end
    tick();
    checks++;
    if ({ERR, DONE, MEM_REQ, BUSY} !== 4'b0000) begin
      errors++;
      $display("FAIL err_idle got err=%b done=%b req=%b busy=%b expected 0000", ERR, DONE, MEM_REQ, BUSY);
    end
  endtask

  task automatic test_load();
    logic [2:0] f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] f3;
    run_load(32'h0000_1003, 3'b000, 5'd9, 32'h80FF_1234, 0, 0, 1'b0);
    run_load(32'h0000_1003, 3'b100, 5'd9, 32'h80FF_1234, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      run_load($urandom & ~(size_of(f3) - 1), f3, 5'($urandom), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  task automatic test_store();
    logic [2:0] f3;
    run_store(32'h0000_2002, 3'b001, 32'hDEAD_BEEF, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      f3 = 3'($urandom_range(0, 2));
      run_store($urandom & ~(size_of(f3) - 1), f3, $urandom, $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_errors();
    bit ld;
    logic [2:0] f3;
    logic [31:0] a;
    run_err(OP_LOAD, 3'b010, 32'h0000_3002);
    run_err(OP_LOAD, 3'b011, 32'h0000_3000);
    run_err(OP_STORE, 3'b001, 32'h0000_4001);
    run_err(OP_STORE, 3'b100, 32'h0000_4000);
    // random mix: illegal ops must error, legal ones must complete normally
    for (int i = 0; i < 12; i++) begin
      ld = 1'($urandom); f3 = 3'($urandom); a = $urandom;
      if (!model_legal(ld, f3, a)) run_err(ld ? OP_LOAD : OP_STORE, f3, a);
      else if (ld) run_load(a, f3, 5'($urandom), $urandom, $urandom_range(0, 2), 0, 1'b0);
      else run_store(a, f3, $urandom, $urandom_range(0, 2), 1'b0);
    end
  endtask

  task automatic test_other_opcode();
    logic [6:0] ops[3] = '{7'b1100011, 7'b1101111, 7'b0000000};
    for (int i = 0; i < 3; i++) begin
      OPCODE = ops[i]; RD = 5'd3; ALU_RESULT = $urandom; START = 1'b1;
      tick();
      START = 1'b0;
      checks++;
      if ({BUSY, DONE, ERR, WB_EN, MEM_REQ} !== 5'b00000) begin
        errors++;
        $display("FAIL other_opcode op=%b got busy=%b done=%b err=%b en=%b req=%b expected 00000",
                 ops[i], BUSY, DONE, ERR, WB_EN, MEM_REQ);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    OPCODE = OP_LOAD; FUNCT3 = 3'b010; RD = 5'd4; ALU_RESULT = 32'h0000_5000; START = 1'b1;
    tick();
    START = 1'b0; MEM_GNT = 1'b1;
    tick();
    MEM_GNT = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; MEM_RVALID = 1'b1; MEM_RDATA = 32'hCAFE_F00D;
    checks++;
    if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, WB_EN, WB_RD, WB_DATA, DONE, ERR, BUSY} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait got req=%b addr=%h en=%b done=%b busy=%b expected all 0",
               MEM_REQ, MEM_ADDR, WB_EN, DONE, BUSY);
    end
    tick();
    MEM_RVALID = 1'b0;
    checks++;
    if ({WB_EN, DONE, ERR, BUSY} !== 4'b0000) begin
      errors++;
      $display("FAIL late_rvalid got en=%b done=%b err=%b busy=%b expected 0000", WB_EN, DONE, ERR, BUSY);
    end
    run_alu(7'b0110011, 5'd12, 32'h0BAD_F00D);
    // START while busy is dropped: the ALU op poked during REQ never writes back
    run_store(32'h0000_6004, 3'b010, 32'h1357_9BDF, 2, 1'b1);
    checks++;
    if ({WB_EN, DONE, BUSY} !== 3'b000) begin
      errors++;
      $display("FAIL start_while_busy got en=%b done=%b busy=%b expected 000", WB_EN, DONE, BUSY);
    end
  endtask

  task automatic test_timeout();
    bit bad;
    OPCODE = OP_LOAD; FUNCT3 = 3'b010; RD = 5'd6; ALU_RESULT = 32'h0000_7000; START = 1'b1;
    tick();
    START = 1'b0; MEM_GNT = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    bad = 0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      if (DONE || ERR || !BUSY) bad = 1;
      tick();
    end
    if (DONE || ERR || !BUSY) bad = 1;
    tick();
    checks++;
    if (bad || {ERR, DONE, WB_EN} !== 3'b110) begin
      errors++;
      $display("FAIL timeout got err=%b done=%b en=%b early=%b expected err=1 done=1 en=0",
               ERR, DONE, WB_EN, bad);
    end
    tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 32'h1111_2222;
    tick();
    MEM_RVALID = 1'b0;
    checks++;
    if ({WB_EN, DONE, ERR, BUSY} !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_late_rvalid got en=%b done=%b err=%b busy=%b expected 0000", WB_EN, DONE, ERR, BUSY);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (DONE || ERR || WB_EN || !BUSY) bad = 1;
      tick();
    end
    checks++;
    if (bad || !BUSY) begin
      errors++;
      $display("FAIL no_timeout got busy=%b early_exit=%b expected busy=1", BUSY, bad);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif
  endtask

  // scenario sequence and final report
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_errors();
    test_other_opcode();
    test_reset_in_wait();
    test_timeout();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_writeback.md
Name: load_store_writeback

Overview:
- Back end of the execute stage: consumes the ALU result/address and store data produced by the operand-select logic and drives register writeback.
- ALU-class ops (OP, OP-IMM, LUI, AUIPC) pass the ALU result to writeback after one registered cycle.
- Loads and stores run a request/grant/response handshake to data memory, with byte-lane masking and sign/zero extension.
- Sits between the ALU and the register file and data-memory port.

Parameters:
TIMEOUT_CYCLES, 16, cycles after grant to wait for MEM_RVALID before aborting a load (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
START  input  1  op valid this cycle; ignored while BUSY=1
OPCODE  input  7  instruction opcode
FUNCT3  input  3  instruction funct3
RD  input  5  destination register
ALU_RESULT  input  32  ALU output; effective address for loads/stores
RS2_DATA  input  32  store data
MEM_REQ  output  1  memory request
MEM_WE  output  1  1 = store, 0 = load
MEM_ADDR  output  32  word address, {addr[31:2],2'b00}
MEM_WDATA  output  32  lane-replicated store data
MEM_BE  output  4  byte enables
MEM_GNT  input  1  request accepted
MEM_RVALID  input  1  read data valid
MEM_RDATA  input  32  read data word
WB_EN  output  1  one-cycle writeback strobe
WB_RD  output  5  writeback register
WB_DATA  output  32  writeback value
DONE  output  1  one-cycle pulse on completion of any op, including errors
ERR  output  1  one-cycle pulse: misaligned access, illegal funct3, or timeout
BUSY  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; op latches cleared. Reset during any state aborts the op with no WB or DONE. A MEM_RVALID arriving later in IDLE is ignored.
- States: IDLE, ALU_WB, REQ, WAIT_R, LD_WB, FIN.
- IDLE + START, transition by opcode:
  - 0010011, 0110011, 0110111, 0010111 -> ALU_WB.
  - 0000011 (load) -> REQ.
  - 0100011 (store) -> REQ.
  - Any other opcode -> stay IDLE, no pulse.
- On the START edge, latch OPCODE, FUNCT3, RD, ALU_RESULT and RS2_DATA. Inputs are don't-care afterwards.
- ALU_WB (1 cycle):
  - WB_EN = (RD != 0), WB_DATA = ALU_RESULT, DONE = 1.
  - Then IDLE. Latency: START at cycle N -> WB at N+1.
- Alignment/legality check, evaluated at the START edge for loads and stores:
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - Load funct3 in {011,110,111} is illegal; store funct3 >= 011 is illegal.
  - On failure: enter FIN with ERR=1, DONE=1, no MEM_REQ, no WB.
- REQ:
  - MEM_REQ=1; MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA held stable until MEM_GNT.
  - Byte enables: SB -> 1<<addr[1:0]; SH -> 0011<<addr[1:0]; SW -> 1111. Loads drive the same masks for information.
  - MEM_WDATA: SB -> {4{b}}, SH -> {2{h}}, SW -> word.
  - On MEM_GNT: store -> FIN (DONE=1); load -> WAIT_R. MEM_REQ drops the cycle after grant.
- WAIT_R:
  - MEM_REQ=0.
  - On MEM_RVALID, capture the extracted lane:
    - LB/LBU: byte at addr[1:0].
    - LH/LHU: half at addr[1].
    - LW: full word.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Then -> LD_WB.
  - MEM_RVALID is only accepted in WAIT_R, so a same-cycle GNT+RVALID is not accepted.
- LD_WB (1 cycle): WB_EN=(RD!=0), WB_RD=RD, WB_DATA=extracted value, DONE=1 -> IDLE.
- Fastest load: START N, MEM_REQ+GNT N+1, RVALID N+2, WB_EN N+3.
- FIN (1 cycle): DONE and, where applicable, ERR -> IDLE.
- WB_EN, DONE and ERR are registered single-cycle pulses; WB_RD/WB_DATA are valid only while WB_EN=1.
- BUSY=1 in every non-IDLE state. START while BUSY is dropped; no queueing.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter clears on grant and increments each WAIT_R cycle. If it reaches TIMEOUT_CYCLES without MEM_RVALID, go to FIN with ERR=1, DONE=1, no WB. A late RVALID in IDLE is ignored.
- Undefined: WAIT_R waits indefinitely; no counter logic is synthesized.

Test Plan:
- ADDI result: START, OPCODE=0010011, RD=5, ALU_RESULT=0x0000_002A -> next cycle WB_EN=1, WB_RD=5, WB_DATA=0x2A, DONE=1; with RD=0 -> WB_EN=0, DONE=1.
- LB: addr 0x1003, MEM_RDATA=0x80FF_1234, GNT immediate, RVALID 1 cycle later -> MEM_ADDR=0x1000, MEM_BE=1000, WB_DATA=0xFFFF_FF80 at N+3. Repeat with LBU -> 0x0000_0080.
- SH: addr 0x2002, RS2_DATA=0xDEAD_BEEF, GNT delayed 3 cycles -> MEM_REQ held 4 cycles with stable MEM_BE=1100, MEM_WDATA=0xBEEF_BEEF; DONE one cycle after GNT; WB_EN never asserted.
- Misaligned LW at 0x3002 and illegal load funct3=011 -> MEM_REQ never asserted; ERR=1, DONE=1 at N+1.
- Reset asserted in WAIT_R, then RVALID=1 one cycle later -> no WB_EN/DONE; all outputs 0; a START two cycles later proceeds normally; START asserted while BUSY -> ignored.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4: grant with no RVALID -> ERR=1, DONE=1 after 4 WAIT_R cycles; without the macro, the block stays BUSY.
